// File: rtl/memory_if.sv
// Data bus between the memory stage and the data memory.
// Signals:
//   mem_req   : request strobe from the memory stage
//   mem_write : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data, already replicated across byte lanes
//   mem_wstrb : byte-lane write enables
//   mem_ready : memory accepts/completes the request this cycle
//   mem_rdata : full read word returned with mem_ready
interface memory_if;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/memory.sv
// Pipeline memory stage: issues loads/stores on the data bus, formats store
// data and load results, and registers the instruction towards writeback.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (ecause 4 load, 6 store) instead of ignoring the low address bits.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   *_in                : execute-side instruction fields
//   stall_in/invalidate : hold outputs / squash the current instruction
//   stall_out           : asks upstream to hold while the bus is busy
//   data_hazard         : destination of the live instruction in this stage
//   bus                 : data bus (memory_if master)
//   *_out               : registered writeback-side fields
module memory (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] csr_data_in,
    input  logic        branch_taken_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic [1:0]  load_store_size_in,
    input  logic        load_signed_in,
    input  logic [1:0]  write_select_in,
    input  logic [5:0]  rd_addr_in,
    input  logic [11:0] csr_addr_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic        valid_in,
    input  logic [3:0]  ecause_in,
    input  logic        exception_in,
    input  logic        stall_in,
    input  logic        invalidate,
    output logic        stall_out,
    output logic [4:0]  data_hazard,
    memory_if.master    bus,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] csr_data_out,
    output logic [31:0] load_data_out,
    output logic        branch_taken_out,
    output logic [1:0]  write_select_out,
    output logic [5:0]  rd_addr_out,
    output logic [11:0] csr_addr_out,
    output logic        mret_out,
    output logic        wfi_out,
    output logic        valid_out,
    output logic [3:0]  ecause_out,
    output logic        exception_out
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned SW   = 4;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            r_state, w_state_next;
    logic              r_req_write, r_req_sign, r_kill, r_buf_valid;
    logic [XLEN-1:0]   r_req_addr, r_req_wdata, r_buf_data;
    logic [SW-1:0]     r_req_wstrb;
    logic [1:0]        r_req_size, r_req_off;

    logic              w_mem_op, w_misaligned, w_access, w_bubble;
    logic              w_req, w_req_g, w_done, w_write, w_sign, w_kill;
    logic              w_advance, w_ld_hit;
    logic [1:0]        w_in_off, w_off, w_size;
    logic [XLEN-1:0]   w_st_data, w_addr, w_wdata, w_load_val;
    logic [SW-1:0]     w_st_strb, w_wstrb;

    // Pick the byte/half lane out of a read word and extend it.
    function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] d,
                                                  input logic [1:0] size,
                                                  input logic sgn,
                                                  input logic [1:0] off);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'd0:    res = {{24{sgn & b[7]}}, b};
            2'd1:    res = {{16{sgn & h[15]}}, h};
            default: res = d;
        endcase
        return res;
    endfunction

    assign w_mem_op = valid_in && !exception_in && !invalidate && (load_in || store_in);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = w_mem_op &&
        (((load_store_size_in == 2'd1) && alu_data_in[0]) ||
         (load_store_size_in[1] && (alu_data_in[1:0] != 2'b00)));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_access = w_mem_op && !w_misaligned;

    // Low address bits that matter for the access size; the rest are ignored.
    always_comb begin
        w_in_off  = 2'b00;
        w_st_data = rs2_data_in;
        w_st_strb = 4'b1111;
        case (load_store_size_in)
            2'd0: begin
                w_in_off  = alu_data_in[1:0];
                w_st_data = {4{rs2_data_in[7:0]}};
                w_st_strb = 4'b0001 << alu_data_in[1:0];
            end
            2'd1: begin
                w_in_off  = {alu_data_in[1], 1'b0};
                w_st_data = {2{rs2_data_in[15:0]}};
                w_st_strb = 4'b0011 << {alu_data_in[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Next state and bus drive; WAIT replays the request latched in IDLE.
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_done       = 1'b0;
        w_write      = store_in;
        w_addr       = {alu_data_in[31:2], 2'b00};
        w_wdata      = w_st_data;
        w_wstrb      = w_st_strb;
        w_size       = load_store_size_in;
        w_sign       = load_signed_in;
        w_off        = w_in_off;
        w_kill       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && !r_buf_valid) begin
                    w_req = 1'b1;
                    if (bus.mem_ready) w_done = 1'b1;
                    else               w_state_next = WAIT;
                end
            end
            WAIT: begin
                w_req   = 1'b1;
                w_write = r_req_write;
                w_addr  = r_req_addr;
                w_wdata = r_req_wdata;
                w_wstrb = r_req_wstrb;
                w_size  = r_req_size;
                w_sign  = r_req_sign;
                w_off   = r_req_off;
                w_kill  = r_kill || invalidate;
                if (bus.mem_ready) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_req_g       = w_req && !reset;
    assign bus.mem_req   = w_req_g;
    assign bus.mem_write = w_req_g && w_write;
    assign bus.mem_addr  = w_addr;
    assign bus.mem_wdata = w_wdata;
    assign bus.mem_wstrb = w_wstrb;
    assign stall_out     = w_req_g && !bus.mem_ready;
    assign data_hazard   = (valid_in && !exception_in && !invalidate) ? rd_addr_in[4:0] : 5'd0;

    assign w_bubble   = !valid_in || invalidate || w_kill;
    assign w_advance  = !stall_in && !(w_req && !bus.mem_ready);
    assign w_load_val = r_buf_valid ? r_buf_data
                                    : f_extract(bus.mem_rdata, w_size, w_sign, w_off);
    assign w_ld_hit   = r_buf_valid || (w_done && !w_write && !w_kill);

    // State, latched request, stalled-result buffer and writeback registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_req_write      <= 1'b0;
            r_req_addr       <= '0;
            r_req_wdata      <= '0;
            r_req_wstrb      <= '0;
            r_req_size       <= '0;
            r_req_sign       <= 1'b0;
            r_req_off        <= '0;
            r_kill           <= 1'b0;
            r_buf_valid      <= 1'b0;
            r_buf_data       <= '0;
            pc_out           <= '0;
            next_pc_out      <= '0;
            alu_data_out     <= '0;
            csr_data_out     <= '0;
            load_data_out    <= '0;
            branch_taken_out <= 1'b0;
            write_select_out <= '0;
            rd_addr_out      <= '0;
            csr_addr_out     <= '0;
            mret_out         <= 1'b0;
            wfi_out          <= 1'b0;
            valid_out        <= 1'b0;
            ecause_out       <= '0;
            exception_out    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE) begin
                r_req_write <= w_write;
                r_req_addr  <= w_addr;
                r_req_wdata <= w_wdata;
                r_req_wstrb <= w_wstrb;
                r_req_size  <= w_size;
                r_req_sign  <= w_sign;
                r_req_off   <= w_off;
                r_kill      <= 1'b0;
            end else if (invalidate) begin
                r_kill <= 1'b1;
            end

            // A completion that cannot retire yet is parked so the bus is not re-used.
            if (w_done && stall_in && !w_kill) begin
                r_buf_valid <= 1'b1;
                r_buf_data  <= w_write ? '0 : w_load_val;
            end else if (!stall_in || invalidate) begin
                r_buf_valid <= 1'b0;
            end

            if (w_advance) begin
                pc_out           <= pc_in;
                next_pc_out      <= next_pc_in;
                alu_data_out     <= alu_data_in;
                csr_data_out     <= csr_data_in;
                load_data_out    <= w_ld_hit ? w_load_val : '0;
                branch_taken_out <= branch_taken_in;
                write_select_out <= write_select_in;
                rd_addr_out      <= rd_addr_in;
                csr_addr_out     <= csr_addr_in;
                mret_out         <= mret_in;
                wfi_out          <= wfi_in;
                valid_out        <= !w_bubble;
                exception_out    <= !w_bubble && (exception_in || w_misaligned);
                ecause_out       <= w_misaligned ? (load_in ? 4'd4 : 4'd6) : ecause_in;
            end else if (!stall_in) begin
                // Waiting on the bus: hand writeback a bubble meanwhile.
                valid_out     <= 1'b0;
                exception_out <= 1'b0;
            end
        end
    end
endmodule

// File: doc/memory.md
MEMORY -- requirements
Module: memory

Interface
- REQ-001: The block SHALL use one clock and a reset that is synchronous and active-high: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
- REQ-002: Execute-side inputs SHALL be: pc_in 32, next_pc_in 32, alu_data_in 32 (address/result), rs2_data_in 32, csr_data_in 32, branch_taken_in 1, load_in 1, store_in 1, load_store_size_in 2 (0 byte, 1 half, 2/3 word), load_signed_in 1, write_select_in 2, rd_addr_in 6, csr_addr_in 12, mret_in 1, wfi_in 1, valid_in 1, ecause_in 4, exception_in 1.
- REQ-003: stall_in in 1 SHALL hold all output registers; invalidate in 1 SHALL turn the current instruction into a bubble.
- REQ-004: stall_out out 1 SHALL request that upstream stages hold; data_hazard out 5 SHALL be rd_addr_in[4:0] when valid_in && !exception_in && !invalidate, else 0.
- REQ-005: The data bus SHALL be: mem_req out 1, mem_write out 1, mem_addr out 32 (word aligned), mem_wdata out 32, mem_wstrb out 4, mem_ready in 1, mem_rdata in 32.
- REQ-006: Writeback-side registered outputs SHALL be: pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out (all 32), branch_taken_out, write_select_out, rd_addr_out, csr_addr_out, mret_out, wfi_out, valid_out, ecause_out, exception_out.

Function
- REQ-007: access = valid_in && !exception_in && !invalidate && (load_in || store_in) && !misaligned.
- REQ-008: The FSM SHALL have states IDLE and WAIT.
- REQ-009: IDLE: mem_req = access; if mem_ready is high in the same cycle, the access completes (1-cycle latency), otherwise the FSM moves to WAIT.
- REQ-010: WAIT: mem_req, mem_write, mem_addr, mem_wdata and mem_wstrb SHALL be held from the latched request until mem_ready, then the FSM returns to IDLE.
- REQ-011: stall_out SHALL be high whenever mem_req is high and mem_ready is low.
- REQ-012: Non-memory instructions SHALL pass through in one cycle with no bus activity.
- REQ-013: mem_addr SHALL be {alu_data_in[31:2], 2'b00}.
- REQ-014: Stores SHALL replicate data (byte ×4, half ×2), with wstrb = 0001<<a[1:0], 0011<<{a[1],0}, or 1111.
- REQ-015: Loads SHALL extract the byte/half selected by a[1:0] and sign- or zero-extend per load_signed_in; word loads SHALL pass through.
- REQ-016: On completion or pass-through with !stall_in, outputs SHALL register the inputs, load_data_out SHALL register the extracted data, and valid_out = valid_in.
- REQ-017: If stall_in is high when mem_ready arrives, the load result SHALL be buffered internally and the bus SHALL NOT be re-requested.
- REQ-018: An invalidate in IDLE SHALL issue no request.
- REQ-019: An invalidate in WAIT SHALL let the transaction finish, discard its result, and register valid_out = 0.
- REQ-020: A bubble (valid_in = 0 or invalidate) SHALL register valid_out = 0 and exception_out = 0.
- REQ-021: An incoming exception_in SHALL pass through unchanged with no bus access.

Reset
- REQ-022: Reset SHALL force the FSM to IDLE and clear all registered outputs, mem_req, stall_out and the internal buffer to 0.
- REQ-023: Reset SHALL take priority over stall_in.
- REQ-024: Reset asserted mid-WAIT SHALL abandon the transaction; mem_req SHALL be low in the first cycle after reset.

Configuration
- REQ-025: With MEM_MISALIGN_TRAP_EN defined, half accesses with a[0] = 1 and word accesses with a[1:0] != 0 SHALL be misaligned.
- REQ-026: A misaligned access SHALL issue no request and SHALL register exception_out = 1 with ecause_out = 4 (load) or 6 (store); the other outputs SHALL register normally.
- REQ-027: Without MEM_MISALIGN_TRAP_EN, misaligned SHALL be 0 and the offending low address bits SHALL be ignored (treated as 0 for half/word).

Verification
- REQ-028: lb, signed, alu_data 0x1003, mem_rdata 0x80xxxxxx, ready same cycle -> load_data_out 0xFFFFFF80, valid_out 1 after one edge, stall_out never high.
- REQ-029: sh at 0x2002 of 0x1234ABCD -> wdata 0xABCDABCD, wstrb 1100, mem_write 1.
- REQ-030: lw with mem_ready delayed 3 cycles -> stall_out high for 3 cycles, bus signals stable, one request, result registered on the ready edge.
- REQ-031: lw at 0x1001 -> with MEM_MISALIGN_TRAP_EN: no mem_req, exception_out 1, ecause_out 4; without: read of 0x1000.
- REQ-032: invalidate during WAIT, then ready -> valid_out 0, FSM IDLE; separately, reset during WAIT -> mem_req 0 next cycle, all outputs 0.
